load_store_unit: RTL and testbench

//  Memory-stage load/store unit between the execute stage and the word-organised data memory.

---
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte-addressed requests become word accesses with strobes, with word-crossing accesses split in two.
// Latency accept->rsp_valid: 2 cycles aligned, 3 split, 1 error; accepts only in IDLE, and the one-cycle response cannot be stalled.
module load_store_unit #(
  parameter int ADDR_W      = 6,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t              state, state_nx;
  logic                accept;
  logic                req_illegal, req_cross, req_err;
  logic                we_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [2:0]          f3_q;
  logic [1:0]          off_q;
  logic                cross_q;
  logic [ADDR_W-1:0]   idx0, idx1;
  logic [7:0]          size_mask, strb8;
  logic [63:0]         data64;
  logic [31:0]         rd0, rd1;
  logic [31:0]         ld_lo, ld_hi, raw, load_ext;
  logic                unused_addr_hi;

  // An access crosses a word boundary when off + size > 4.
  function automatic logic crosses(input logic [1:0] off, input logic [1:0] sz);
    return ((sz == 2'b10) && (off != 2'b00)) || ((sz == 2'b01) && (off == 2'b11));
  endfunction

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign req_ready   = (state == IDLE);
  assign accept      = req_valid && req_ready;
  assign req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_we && req_funct3[2]);
  assign req_cross   = crosses(req_addr[1:0], req_funct3[1:0]);
  assign req_err     = req_illegal || (req_cross && !MISALIGN_EN);

  assign off_q   = addr_q[1:0];
  assign cross_q = crosses(off_q, f3_q[1:0]);
  assign idx0    = addr_q[ADDR_W+1:2];
  assign idx1    = idx0 + ADDR_W'(1);

  always_comb begin
    size_mask = 8'h01;
    case (f3_q[1:0])
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'h01;
    endcase
  end

  assign strb8  = size_mask << off_q;
  assign data64 = {32'b0, wdata_q} << {off_q, 3'b000};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = req_err ? RESP : ACC0;
      ACC0:    state_nx = cross_q ? ACC1 : RESP;
      ACC1:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0;
    mem_wdata = 32'b0;
    case (state)
      ACC0: begin
        mem_we    = we_q;
        mem_addr  = idx0;
        mem_be    = strb8[3:0];
        mem_wdata = data64[31:0];
      end
      ACC1: begin
        mem_we    = we_q;
        mem_addr  = idx1;
        mem_be    = strb8[7:4];
        mem_wdata = data64[63:32];
      end
      default: ;
    endcase
  end

  // Live read data is folded in so the response can be registered on the last access edge.
  always_comb begin
    ld_lo = rd0;
    ld_hi = rd1;
    if (state == ACC0) begin
      ld_lo = mem_rdata;
      ld_hi = 32'b0;
    end else if (state == ACC1) begin
      ld_hi = mem_rdata;
    end
  end

  assign raw = 32'({ld_hi, ld_lo} >> {off_q, 3'b000});

  always_comb begin
    load_ext = 32'b0;
    case (f3_q)
      3'b000:  load_ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  load_ext = {{16{raw[15]}}, raw[15:0]};
      3'b010:  load_ext = raw;
      3'b100:  load_ext = {24'b0, raw[7:0]};
      3'b101:  load_ext = {16'b0, raw[15:0]};
      default: load_ext = 32'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'b0;
      f3_q      <= 3'b0;
      rd0       <= 32'b0;
      rd1       <= 32'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'b0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr[ADDR_W+1:0];
        wdata_q <= req_wdata;
        f3_q    <= req_funct3;
      end
      if (state == ACC0) begin
        rd0 <= mem_rdata;
        rd1 <= 32'b0;
      end
      if (state == ACC1) rd1 <= mem_rdata;
      rsp_valid <= (state_nx == RESP);
      rsp_err   <= accept && req_err;
      rsp_rdata <= ((state == ACC0 || state == ACC1) && state_nx == RESP && !we_q) ?
                   load_ext : 32'b0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of requests with hand-computed responses and memory accesses,
// plus hand sequences for reset during a split store and the MISALIGN_EN=0 variant.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        v1, rdy1, we1, mwe1, rv1, re1;
  logic [31:0] a1, wd1, mwd1, rd1;
  logic [2:0]  f31;
  logic [5:0]  ma1;
  logic [3:0]  mbe1;
  logic [31:0] mem_rdata1 = 32'hA5A50F0F;
  logic        we1_seen = 1'b0;

  logic [31:0] mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_val = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(6), .MISALIGN_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  load_store_unit #(.ADDR_W(6), .MISALIGN_EN(1'b0)) dut_nomis (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_addr(a1), .req_wdata(wd1), .req_funct3(f31),
    .mem_we(mwe1), .mem_addr(ma1), .mem_be(mbe1),
    .mem_wdata(mwd1), .mem_rdata(mem_rdata1),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  always @(posedge clk) if (mwe1) we1_seen <= 1'b1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_nacc;
    logic [5:0]  a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [5:0]  a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] f3, input logic [31:0] exp_rdata, input logic exp_err,
                              input int lat, input int nacc,
                              input logic [5:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                              input logic [5:0] a1, input logic [3:0] be1, input logic [31:0] wd1);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = lat; v.exp_nacc = nacc;
    v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.a1 = a1; v.be1 = be1; v.wd1 = wd1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic do_req(input vec_t v, input int id);
    int         lat, nacc;
    bit         got;
    logic [5:0] aa [2];
    logic [3:0] bb [2];
    logic [31:0] ww [2];
    logic       wv [2];
    @(negedge clk);
    chk($sformatf("v%0d req_ready", id), {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_funct3 = v.f3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nacc = 0; got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (mem_be != 4'b0) begin
        if (nacc < 2) begin
          aa[nacc] = mem_addr; bb[nacc] = mem_be; ww[nacc] = mem_wdata; wv[nacc] = mem_we;
        end
        nacc++;
      end
      if (rsp_valid) got = 1'b1;
    end
    chk($sformatf("v%0d rsp_valid seen", id), {31'b0, got}, 32'd1);
    chk($sformatf("v%0d latency", id), lat, v.exp_lat);
    chk($sformatf("v%0d rsp_rdata", id), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d rsp_err", id), {31'b0, rsp_err}, {31'b0, v.exp_err});
    chk($sformatf("v%0d accesses", id), nacc, v.exp_nacc);
    for (int i = 0; i < 2; i++) begin
      if (i < v.exp_nacc && i < nacc) begin
        chk($sformatf("v%0d acc%0d addr", id, i), {26'b0, aa[i]}, {26'b0, (i == 0) ? v.a0 : v.a1});
        chk($sformatf("v%0d acc%0d be", id, i), {28'b0, bb[i]}, {28'b0, (i == 0) ? v.be0 : v.be1});
        chk($sformatf("v%0d acc%0d wdata", id, i), ww[i], (i == 0) ? v.wd0 : v.wd1);
        chk($sformatf("v%0d acc%0d we", id, i), {31'b0, wv[i]}, {31'b0, v.we});
      end
    end
    @(negedge clk);
    chk($sformatf("v%0d rsp_valid drop", id), {31'b0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d rsp_rdata idle", id), rsp_rdata, 32'd0);
    chk($sformatf("v%0d rsp_err idle", id), {31'b0, rsp_err}, 32'd0);
  endtask

  vec_t vt [21];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(0, 32'h0B, 0, 3'b000, 32'hFFFFFF88, 0, 2, 1, 2, 4'b1000, 0, 0, 0, 0);
    vt[1]  = mk(0, 32'h0A, 0, 3'b101, 32'h00008899, 0, 2, 1, 2, 4'b1100, 0, 0, 0, 0);
    vt[2]  = mk(0, 32'h08, 0, 3'b001, 32'hFFFFAABB, 0, 2, 1, 2, 4'b0011, 0, 0, 0, 0);
    vt[3]  = mk(0, 32'h09, 0, 3'b100, 32'h000000AA, 0, 2, 1, 2, 4'b0010, 0, 0, 0, 0);
    vt[4]  = mk(0, 32'h08, 0, 3'b010, 32'h8899AABB, 0, 2, 1, 2, 4'b1111, 0, 0, 0, 0);
    vt[5]  = mk(1, 32'h0D, 32'hDEADBEEF, 3'b010, 0, 0, 3, 2, 3, 4'b1110, 32'hADBEEF00, 4, 4'b0001, 32'h000000DE);
    vt[6]  = mk(0, 32'h0D, 0, 3'b010, 32'hDEADBEEF, 0, 3, 2, 3, 4'b1110, 0, 4, 4'b0001, 0);
    vt[7]  = mk(0, 32'hFF, 0, 3'b010, 32'h66778811, 0, 3, 2, 63, 4'b1000, 0, 0, 4'b0111, 0);
    vt[8]  = mk(1, 32'h13, 32'h1234ABCD, 3'b001, 0, 0, 3, 2, 4, 4'b1000, 32'hCD000000, 5, 4'b0001, 32'h001234AB);
    vt[9]  = mk(0, 32'h13, 0, 3'b001, 32'hFFFFABCD, 0, 3, 2, 4, 4'b1000, 0, 5, 4'b0001, 0);
    vt[10] = mk(1, 32'h06, 32'h5A5A5A7E, 3'b000, 0, 0, 2, 1, 1, 4'b0100, 32'h5A7E0000, 0, 0, 0);
    vt[11] = mk(0, 32'h06, 0, 3'b000, 32'h0000007E, 0, 2, 1, 1, 4'b0100, 0, 0, 0, 0);
    vt[12] = mk(1, 32'h02, 32'hFFFF8001, 3'b001, 0, 0, 2, 1, 0, 4'b1100, 32'h80010000, 0, 0, 0);
    vt[13] = mk(0, 32'h02, 0, 3'b101, 32'h00008001, 0, 2, 1, 0, 4'b1100, 0, 0, 0, 0);
    vt[14] = mk(0, 32'h00, 0, 3'b010, 32'h80017788, 0, 2, 1, 0, 4'b1111, 0, 0, 0, 0);
    vt[15] = mk(0, 32'h08, 0, 3'b011, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vt[16] = mk(1, 32'h08, 32'hFFFFFFFF, 3'b100, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vt[17] = mk(0, 32'h08, 0, 3'b110, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vt[18] = mk(1, 32'h08, 32'h12345678, 3'b101, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vt[19] = mk(0, 32'h0B, 0, 3'b001, 32'h00000088, 0, 3, 2, 2, 4'b1000, 0, 3, 4'b0001, 0);
    vt[20] = mk(0, 32'h04, 0, 3'b010, 32'h007E0000, 0, 2, 1, 1, 4'b1111, 0, 0, 0, 0);

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
    v1 = 1'b0; we1 = 1'b0; a1 = 0; wd1 = 0; f31 = 0;

    for (int i = 0; i < 64; i++) preload(6'(i), 32'd0);
    preload(6'd2, 32'h8899AABB);
    preload(6'd63, 32'h11223344);
    preload(6'd0, 32'h55667788);

    @(negedge clk);
    chk("reset req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset mem_we", {31'b0, mem_we}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) do_req(vt[i], i);

    // Reset in the middle of a split store: only the first word lands.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h2A; req_wdata = 32'hCAFEF00D; req_funct3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("split acc0 addr", {26'b0, mem_addr}, 32'd10);
    chk("split acc0 be", {28'b0, mem_be}, 32'b1100);
    @(negedge clk);
    chk("split acc1 we", {31'b0, mem_we}, 32'd1);
    chk("split acc1 addr", {26'b0, mem_addr}, 32'd11);
    chk("split acc1 wdata", mem_wdata, 32'h0000CAFE);
    rst_n = 1'b0;
    #1;
    chk("abort mem_we", {31'b0, mem_we}, 32'd0);
    chk("abort mem_be", {28'b0, mem_be}, 32'd0);
    chk("abort mem_addr", {26'b0, mem_addr}, 32'd0);
    chk("abort mem_wdata", mem_wdata, 32'd0);
    chk("abort req_ready", {31'b0, req_ready}, 32'd1);
    chk("abort rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(mk(0, 32'h28, 0, 3'b010, 32'hF00D0000, 0, 2, 1, 10, 4'b1111, 0, 0, 0, 0), 100);
    do_req(mk(0, 32'h2C, 0, 3'b010, 32'h00000000, 0, 2, 1, 11, 4'b1111, 0, 0, 0, 0), 101);

    // MISALIGN_EN=0 instance: crossing requests are rejected without touching memory.
    @(negedge clk);
    chk("nomis ready", {31'b0, rdy1}, 32'd1);
    v1 = 1'b1; we1 = 1'b0; a1 = 32'hFF; f31 = 3'b010;
    @(posedge clk);
    #1 v1 = 1'b0;
    @(negedge clk);
    chk("nomis lw err valid", {31'b0, rv1}, 32'd1);
    chk("nomis lw err", {31'b0, re1}, 32'd1);
    chk("nomis lw rdata", rd1, 32'd0);
    @(negedge clk);
    chk("nomis rsp drop", {31'b0, rv1}, 32'd0);
    v1 = 1'b1; we1 = 1'b1; a1 = 32'h03; wd1 = 32'h0000BEEF; f31 = 3'b001;
    @(posedge clk);
    #1 v1 = 1'b0;
    @(negedge clk);
    chk("nomis sh err", {31'b0, re1}, 32'd1);
    @(negedge clk);
    v1 = 1'b1; we1 = 1'b0; a1 = 32'h04; f31 = 3'b010;
    @(posedge clk);
    #1 v1 = 1'b0;
    @(negedge clk);
    chk("nomis aligned acc addr", {26'b0, ma1}, 32'd1);
    chk("nomis aligned not yet valid", {31'b0, rv1}, 32'd0);
    @(negedge clk);
    chk("nomis aligned valid", {31'b0, rv1}, 32'd1);
    chk("nomis aligned err", {31'b0, re1}, 32'd0);
    chk("nomis aligned rdata", rd1, 32'hA5A50F0F);
    @(negedge clk);
    chk("nomis never wrote", {31'b0, we1_seen}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
